// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: a FETCH/DECODE/EXEC/MEM/WB state machine that
// produces datapath enables and selects from the current state and instruction.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Eq,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic       MemWr,
  output logic [3:0] Aluop,
  output logic [1:0] ALUSrcB,
  output logic       ShamtSel,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] NPCSel,
  output logic       Retire,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    InAddu, InSubu, InSll, InJr, InOri, InLw, InSw, InBeq, InLui, InJ, InJal, InNop
  } instr_e;

  state_e r_state;
  state_e w_state_d;
  instr_e w_instr;

  always_comb begin
    w_instr = InNop;
    case (Op)
      6'b000000: begin
        case (Funct)
          6'b100001: w_instr = InAddu;
          6'b100011: w_instr = InSubu;
          6'b000000: w_instr = InSll;
          6'b001000: w_instr = InJr;
          default:   w_instr = InNop;
        endcase
      end
      6'b001101: w_instr = InOri;
      6'b100011: w_instr = InLw;
      6'b101011: w_instr = InSw;
      6'b000100: w_instr = InBeq;
      6'b001111: w_instr = InLui;
      6'b000010: w_instr = InJ;
      6'b000011: w_instr = InJal;
      default:   w_instr = InNop;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = StFetch;
    PCWr      = 1'b0;
    IRWr      = 1'b0;
    RegWr     = 1'b0;
    MemWr     = 1'b0;
    Aluop     = 4'b0000;
    ALUSrcB   = 2'b00;
    ShamtSel  = 1'b0;
    RegDst    = 2'b00;
    WDSel     = 2'b00;
    NPCSel    = 2'b00;
    Retire    = 1'b0;

    case (r_state)
      StFetch: begin
        IRWr      = 1'b1;
        PCWr      = 1'b1;
        w_state_d = StDecode;
      end
      StDecode: begin
        case (w_instr)
          InJ: begin
            PCWr   = 1'b1;
            NPCSel = 2'b10;
            Retire = 1'b1;
          end
          InJal: begin
            PCWr   = 1'b1;
            NPCSel = 2'b10;
            RegWr  = 1'b1;
            RegDst = 2'b10;
            WDSel  = 2'b10;
            Retire = 1'b1;
          end
          InJr: begin
            PCWr   = 1'b1;
            NPCSel = 2'b11;
            Retire = 1'b1;
          end
          InNop:   Retire = 1'b1;
          default: w_state_d = StExec;
        endcase
      end
      StExec: begin
        case (w_instr)
          InAddu: w_state_d = StWb;
          InSubu: begin
            Aluop     = 4'b0001;
            w_state_d = StWb;
          end
          InSll: begin
            Aluop     = 4'b0100;
            w_state_d = StWb;
          end
          InOri: begin
            Aluop     = 4'b0010;
            ALUSrcB   = 2'b01;
            w_state_d = StWb;
          end
          InLui: begin
            Aluop     = 4'b0100;
            ALUSrcB   = 2'b01;
            ShamtSel  = 1'b1;
            w_state_d = StWb;
          end
          InLw, InSw: begin
            ALUSrcB   = 2'b10;
            w_state_d = StMem;
          end
          InBeq: begin
            Aluop  = 4'b0011;
            PCWr   = Eq;
            NPCSel = 2'b01;
            Retire = 1'b1;
          end
          default: w_state_d = StFetch;
        endcase
      end
      StMem: begin
        if (w_instr == InSw) begin
          MemWr  = 1'b1;
          Retire = 1'b1;
        end else begin
          w_state_d = StWb;
        end
      end
      StWb: begin
        RegWr  = 1'b1;
        Retire = 1'b1;
        case (w_instr)
          InAddu, InSubu, InSll: RegDst = 2'b01;
          InLw:                  WDSel  = 2'b01;
          default:               RegDst = 2'b00;
        endcase
      end
      default: w_state_d = StFetch;
    endcase

    // Reset silences every output so an abandoned instruction cannot write.
    if (reset) begin
      w_state_d = StFetch;
      PCWr      = 1'b0;
      IRWr      = 1'b0;
      RegWr     = 1'b0;
      MemWr     = 1'b0;
      Aluop     = 4'b0000;
      ALUSrcB   = 2'b00;
      ShamtSel  = 1'b0;
      RegDst    = 2'b00;
      WDSel     = 2'b00;
      NPCSel    = 2'b00;
      Retire    = 1'b0;
    end
  end

  assign State = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomised self-checking bench for mc_ctrl against a per-instruction cycle-script model.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Eq;
  logic       PCWr, IRWr, RegWr, MemWr, ShamtSel, Retire;
  logic [3:0] Aluop;
  logic [1:0] ALUSrcB, RegDst, WDSel, NPCSel;
  logic [2:0] State;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Eq(Eq),
    .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr), .Aluop(Aluop),
    .ALUSrcB(ALUSrcB), .ShamtSel(ShamtSel), .RegDst(RegDst), .WDSel(WDSel),
    .NPCSel(NPCSel), .Retire(Retire), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwr, irwr, regwr, memwr;
    logic [3:0] aluop;
    logic [1:0] srcb;
    logic       shamt;
    logic [1:0] regdst, wdsel, npcsel;
    logic       retire;
  } rec_t;

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  rec_t obs_q[$];

  function automatic rec_t sample();
    rec_t r;
    r = '{State, PCWr, IRWr, RegWr, MemWr, Aluop, ALUSrcB, ShamtSel, RegDst, WDSel, NPCSel,
          Retire};
    return r;
  endfunction

  function automatic rec_t blank(input logic [2:0] st);
    rec_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  // Reference: build the instruction's cycle-by-cycle script from its class.
  function automatic void build(input logic [5:0] op, input logic [5:0] fn, input logic eq);
    string k;
    rec_t  r;
    k = "nop";
    if (op == 6'b000000) begin
      if (fn == 6'b100001) k = "addu";
      else if (fn == 6'b100011) k = "subu";
      else if (fn == 6'b000000) k = "sll";
      else if (fn == 6'b001000) k = "jr";
    end
    else if (op == 6'b001101) k = "ori";
    else if (op == 6'b100011) k = "lw";
    else if (op == 6'b101011) k = "sw";
    else if (op == 6'b000100) k = "beq";
    else if (op == 6'b001111) k = "lui";
    else if (op == 6'b000010) k = "j";
    else if (op == 6'b000011) k = "jal";

    exp_q.delete();
    r = blank(3'd0); r.irwr = 1; r.pcwr = 1; exp_q.push_back(r);
    r = blank(3'd1);
    if (k == "j" || k == "jal" || k == "jr" || k == "nop") begin
      r.retire = 1;
      if (k != "nop") r.pcwr = 1;
      if (k == "jr") r.npcsel = 2'b11;
      if (k == "j" || k == "jal") r.npcsel = 2'b10;
      if (k == "jal") begin r.regwr = 1; r.regdst = 2'b10; r.wdsel = 2'b10; end
      exp_q.push_back(r);
      return;
    end
    exp_q.push_back(r);
    r = blank(3'd2);
    if (k == "subu") r.aluop = 4'b0001;
    if (k == "sll" || k == "lui") r.aluop = 4'b0100;
    if (k == "ori") r.aluop = 4'b0010;
    if (k == "ori" || k == "lui") r.srcb = 2'b01;
    if (k == "lui") r.shamt = 1;
    if (k == "lw" || k == "sw") r.srcb = 2'b10;
    if (k == "beq") begin
      r.aluop = 4'b0011; r.pcwr = eq; r.npcsel = 2'b01; r.retire = 1;
      exp_q.push_back(r);
      return;
    end
    exp_q.push_back(r);
    if (k == "lw" || k == "sw") begin
      r = blank(3'd3);
      if (k == "sw") begin
        r.memwr = 1; r.retire = 1;
        exp_q.push_back(r);
        return;
      end
      exp_q.push_back(r);
    end
    r = blank(3'd4);
    r.regwr = 1; r.retire = 1;
    if (k == "lw") r.wdsel = 2'b01;
    if (k == "addu" || k == "subu" || k == "sll") r.regdst = 2'b01;
    exp_q.push_back(r);
  endfunction

  // Runs n cycles from FETCH, sampling #1 after each edge. Eq is random except in cycle 2.
  task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                            input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      Op = op; Funct = fn;
      Eq = (i == 2) ? eq : 1'($urandom);
      #1;
      obs_q.push_back(sample());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rec_t z;
    reset = 1; Op = 0; Funct = 0; Eq = 1;
    @(posedge clk); #1;
    z = blank(3'd0);
    checks++;
    if (sample() !== z) begin
      errors++; $display("FAIL reset_hold got %h want %h", sample(), z);
    end
    @(posedge clk); #1;
    checks++;
    if (sample() !== z) begin
      errors++; $display("FAIL reset_hold2 got %h want %h", sample(), z);
    end
    reset = 0; #1;
    z.irwr = 1; z.pcwr = 1;
    checks++;
    if (sample() !== z) begin
      errors++; $display("FAIL reset_fetch got %h want %h", sample(), z);
    end
  endtask

  task automatic run_named(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic eq);
    build(op, fn, eq);
    exec_instr(op, fn, eq, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d got %h want %h", name, i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_addu();   run_named("addu", 6'b000000, 6'b100001, 1'b0); endtask
  task automatic test_lw();     run_named("lw", 6'b100011, 6'($urandom), 1'b1); endtask
  task automatic test_beq();
    run_named("beq_eq1", 6'b000100, 6'($urandom), 1'b1);
    run_named("beq_eq0", 6'b000100, 6'($urandom), 1'b0);
  endtask
  task automatic test_lui_jal();
    run_named("lui", 6'b001111, 6'($urandom), 1'b0);
    run_named("jal", 6'b000011, 6'($urandom), 1'b1);
    run_named("j", 6'b000010, 6'($urandom), 1'b0);
    run_named("jr", 6'b000000, 6'b001000, 1'b0);
  endtask
  task automatic test_illegal();
    run_named("op_3f", 6'b111111, 6'b100001, 1'b1);
    run_named("rtype_bad_funct", 6'b000000, 6'b111111, 1'b0);
  endtask

  task automatic test_reset_in_mem();
    rec_t r;
    build(6'b101011, 6'd0, 1'b0);
    exec_instr(6'b101011, 6'd0, 1'b0, 3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL sw_pre cycle %0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    reset = 1; #1;
    r = blank(3'd3);
    checks++;
    if (sample() !== r) begin
      errors++; $display("FAIL sw_mem_reset got %h want %h", sample(), r);
    end
    @(posedge clk); #1;
    r = blank(3'd0);
    checks++;
    if (sample() !== r) begin
      errors++; $display("FAIL sw_after_reset got %h want %h", sample(), r);
    end
    reset = 0;
  endtask

  task automatic test_random();
    logic [5:0] ops[11] = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b100011, 6'b101011,
                            6'b000100, 6'b001111, 6'b000010, 6'b000011, 6'b000000};
    logic [5:0] fns[4] = '{6'b100001, 6'b100011, 6'b000000, 6'b001000};
    logic [5:0] op, fn;
    for (int n = 0; n < 200; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 10)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 3)];
      run_named("random", op, fn, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw();
    test_beq();
    test_lui_jal();
    test_illegal();
    test_reset_in_mem();
    test_addu();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have no parameters; opcodes and funct codes are fixed constants (MIPS encoding).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-004 SHALL have port: Op  input  6  IR[31:26], stable from the cycle after FETCH.
REQ-005 SHALL have port: Funct  input  6  IR[5:0].
REQ-006 SHALL have port: Eq  input  1  ALU Result[0] in the current cycle.
REQ-007 SHALL have port: PCWr  output  1  PC load enable.
REQ-008 SHALL have port: IRWr  output  1  IR load enable.
REQ-009 SHALL have port: RegWr  output  1  GRF write enable.
REQ-010 SHALL have port: MemWr  output  1  DM write enable.
REQ-011 SHALL have port: Aluop  output  4  0000 add, 0001 sub, 0010 or, 0011 eq, 0100 shift-left.
REQ-012 SHALL have port: ALUSrcB  output  2  00 rt value, 01 zero-ext imm16, 10 sign-ext imm16.
REQ-013 SHALL have port: ShamtSel  output  1  0 IR[10:6], 1 constant 16.
REQ-014 SHALL have port: RegDst  output  2  00 rt, 01 rd, 10 register 31.
REQ-015 SHALL have port: WDSel  output  2  00 ALUOut, 01 MDR, 10 PC.
REQ-016 SHALL have port: NPCSel  output  2  00 PC+4, 01 branch target, 10 jump target, 11 rs value.
REQ-017 SHALL have port: Retire  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-018 SHALL have port: State  output  3  current state code, for debug.

Function
REQ-019 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 go to FETCH on the next edge with all enables 0.
REQ-020 SHALL, in FETCH, assert IRWr=1, PCWr=1, NPCSel=00, Aluop=0000, then go to DECODE.
REQ-021 SHALL decode: R-type (Op=000000) with Funct addu 100001, subu 100011, sll 000000, jr 001000; ori 001101; lw 100011; sw 101011; beq 000100; lui 001111; j 000010; jal 000011.
REQ-022 SHALL, in DECODE for j, assert PCWr=1, NPCSel=10, Retire=1, then go to FETCH.
REQ-023 SHALL, in DECODE for jal, additionally assert RegWr=1, RegDst=10, WDSel=10; PC then holds instruction address+4.
REQ-024 SHALL, in DECODE for jr, assert PCWr=1, NPCSel=11, Retire=1, then go to FETCH.
REQ-025 SHALL treat an unrecognised Op/Funct as nop: DECODE asserts Retire=1 and no other enable, then goes to FETCH.
REQ-026 SHALL, for other decoded instructions, go from DECODE to EXEC with all enables 0.
REQ-027 SHALL drive EXEC as: addu 0000/ALUSrcB 00; subu 0001/00; sll 0100/00, ShamtSel 0; ori 0010/01; lui 0100/01, ShamtSel 1; lw, sw 0000/10; beq 0011/00.
REQ-028 SHALL, in EXEC for beq, assert PCWr=Eq, NPCSel=01, Retire=1, then go to FETCH.
REQ-029 SHALL go from EXEC to MEM for lw/sw, and to WB for addu/subu/sll/ori/lui.
REQ-030 SHALL, in MEM, assert MemWr=1 and Retire=1 for sw (then FETCH); for lw assert nothing (then WB).
REQ-031 SHALL, in WB, assert RegWr=1 and Retire=1 with RegDst=01/WDSel=00 for R-type, RegDst=00/WDSel=00 for ori/lui, RegDst=00/WDSel=01 for lw; then go to FETCH.
REQ-032 SHALL drive every output not listed for a state to 0 (Aluop 0000, selects 00).
REQ-033 SHALL give cycle counts: j/jal/jr/nop 2, beq 3, addu/subu/sll/ori/lui/sw 4, lw 5.
REQ-034 SHALL produce outputs combinationally from State, Op, Funct and Eq only (Moore plus Eq for beq PCWr).

Reset
REQ-035 SHALL, while reset=1, force all enables and Retire to 0, regardless of state.
REQ-036 SHALL enter FETCH on the first rising edge with reset=1; reset mid-instruction abandons it with no further writes.
REQ-037 SHALL, on the first edge after reset deasserts, perform a FETCH (IRWr=PCWr=1).

Verification
REQ-038 SHALL cover: reset, then addu (Op 000000, Funct 100001) -> States 0,1,2,4; Aluop 0000 in EXEC; RegWr=1, RegDst=01, Retire=1 in WB.
REQ-039 SHALL cover: lw (100011) -> 5 cycles; ALUSrcB=10 in EXEC; MemWr=0 in MEM; RegWr=1, WDSel=01 in WB.
REQ-040 SHALL cover: beq with Eq=1 then Eq=0 -> PCWr=1 then 0 in EXEC, NPCSel=01, back to FETCH after 3 cycles.
REQ-041 SHALL cover: lui (001111) -> Aluop 0100, ShamtSel 1, ALUSrcB 01; jal (000011) -> RegWr=1, RegDst=10, WDSel=10, NPCSel=10 in DECODE.
REQ-042 SHALL cover: Op 111111 -> Retire=1 in DECODE, no write enables, back to FETCH.
REQ-043 SHALL cover: reset asserted in MEM of sw -> MemWr=0 that cycle, State=0 after the edge.
